// File: rtl/mips32_mem_pkg.sv
// Shared types and constants for the MIPS32 unified-memory arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mips32_mem_pkg;

   // Arbiter FSM: idle, or owning the memory on behalf of fetch or data.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_t;

   // Word returned to a load or fetch that the watchdog aborted.
   localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

   localparam int DEF_TIMEOUT_CYC  = 255;
   localparam int DEF_MAX_D_STREAK = 4;

endpackage

// File: rtl/mips32_mem_arbiter.sv
// Arbitrates one single-ported variable-latency memory between fetch (I) and data (D) ports.
// Latency: grant registered at cycle N, mem_req from N+1, ack pulse the cycle after mem_ack.
// Backpressure: req/ack handshake; stall_if/stall_mem are high while a port's request is unacked.
module mips32_mem_arbiter
   import mips32_mem_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MAX_D_STREAK = DEF_MAX_D_STREAK,
   parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [3:0]        d_be,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              mem_req,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              err_timeout
);

   localparam int ST_W = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
   localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [ST_W-1:0]   ST_MAX   = ST_W'(MAX_D_STREAK);
   // Counter value seen during the last unacked cycle before the abort.
   localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
   localparam bit                WD_EN    = (TIMEOUT_CYC != 0);
   localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_DATA);

   arb_state_t      state, state_nxt;
   logic [ST_W-1:0] streak;
   logic [WD_W-1:0] wd_cnt;
   logic            i_elig, d_elig;
   logic            grant_i, grant_d;
   logic            done, expire;

   // A port whose ack is high this cycle is still presenting the request being retired.
   assign i_elig    = i_req & ~i_ack;
   assign d_elig    = d_req & ~d_ack;
   assign stall_if  = i_req & ~i_ack;
   assign stall_mem = d_req & ~d_ack;

   // Next-state logic: grant selection in IDLE, completion or watchdog abort when busy.
   always_comb begin
      state_nxt = state;
      grant_i   = 1'b0;
      grant_d   = 1'b0;
      done      = 1'b0;
      expire    = 1'b0;
      case (state)
         IDLE: begin
            if (i_elig && (!d_elig || streak == ST_MAX)) begin
               grant_i   = 1'b1;
               state_nxt = BUSY_I;
            end else if (d_elig) begin
               grant_d   = 1'b1;
               state_nxt = BUSY_D;
            end
         end
         BUSY_I, BUSY_D: begin
            // A real ack wins over a watchdog expiry landing in the same cycle.
            if (mem_ack) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end else if (WD_EN && wd_cnt == WD_LAST) begin
               expire    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Memory-side request fields and per-port response registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= 4'h0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         i_ack     <= 1'b0;
         d_ack     <= 1'b0;
         i_rdata   <= '0;
         d_rdata   <= '0;
      end else begin
         i_ack <= 1'b0;
         d_ack <= 1'b0;
         if (grant_i) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_be    <= 4'hF;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
         end else if (grant_d) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_be    <= d_be;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
         end else if (done || expire) begin
            mem_req <= 1'b0;
            if (state == BUSY_I) begin
               i_ack   <= 1'b1;
               i_rdata <= done ? mem_rdata : ERR_WORD;
            end else begin
               d_ack <= 1'b1;
               // Stores leave the last load data in place.
               if (!mem_we) d_rdata <= done ? mem_rdata : ERR_WORD;
            end
         end
      end
   end

   // Consecutive D grants made while fetch waits; gives I the slot once it saturates.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         streak <= '0;
      end else if (!i_req || grant_i) begin
         streak <= '0;
      end else if (grant_d && streak != ST_MAX) begin
         streak <= streak + ST_W'(1);
      end
   end

   // Watchdog: counts busy cycles without mem_ack, restarted by each grant.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wd_cnt <= '0;
      end else if (grant_i || grant_d) begin
         wd_cnt <= '0;
      end else if (WD_EN && state != IDLE && !mem_ack && !expire) begin
         wd_cnt <= wd_cnt + WD_W'(1);
      end
   end

   // Sticky timeout flag, cleared only by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      err_timeout <= 1'b0;
      else if (expire) err_timeout <= 1'b1;
   end

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Self-checking bench for mips32_mem_arbiter: directed scenarios plus randomized traffic.
// Latency: a transaction-level model predicts every registered output cycle by cycle.
// Backpressure: bench requesters hold req until ack and change it the cycle after.
module tb_mips32_mem_arbiter;

   localparam int MAXS = 4;
   localparam int TO   = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [3:0]  d_be;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        stall_if;
   logic        stall_mem;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        err_timeout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mips32_mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAXS), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .err_timeout(err_timeout)
   );

   // ---------------- reference model: one outstanding memory transaction ----------------
   int          m_owner;    // 0 none, 1 fetch, 2 data
   logic        m_req, m_we, m_ia, m_da, m_err;
   logic [3:0]  m_be;
   logic [31:0] m_addr, m_wdata, m_ir, m_dr;
   int          m_streak, m_waited;

   // memory model and requester state
   bit          auto_mode;
   int          next_lat, mem_lat, mem_cnt;
   logic        i_ack_prev, d_ack_prev;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h40) return 32'h1234;
      return a ^ 32'hA5A5_0F0F;
   endfunction

   function automatic int pick_lat();
      int r;
      r = $urandom_range(15, 0);
      if (r == 0) return 0;          // never acks: watchdog abort
      if (r == 1) return TO;         // ack lands on the timeout cycle
      return $urandom_range(4, 1);
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = 0; m_req = 0; m_we = 0; m_be = 0; m_addr = 0; m_wdata = 0;
      m_ir = 0; m_dr = 0; m_ia = 0; m_da = 0; m_err = 0; m_streak = 0; m_waited = 0;
   endtask

   // Advance the model by one clock using the inputs the DUT samples on this edge.
   task automatic model_clock();
      logic ia, da, gi, gd, ie, de;
      logic [31:0] word;
      ia = 0; da = 0; gi = 0; gd = 0;
      ie = i_req && !m_ia;
      de = d_req && !m_da;
      if (m_owner == 0) begin
         if (ie && (!de || m_streak == MAXS)) gi = 1;
         else if (de) gd = 1;
         if (gi) begin
            m_owner = 1; m_req = 1; m_we = 0; m_be = 4'hF;
            m_addr = i_addr; m_wdata = 0; m_waited = 0;
         end
         if (gd) begin
            m_owner = 2; m_req = 1; m_we = d_we; m_be = d_be;
            m_addr = d_addr; m_wdata = d_wdata; m_waited = 0;
         end
      end else if (mem_ack || (m_waited + 1 == TO)) begin
         word = mem_ack ? mem_rdata : 32'hDEADBEEF;
         if (!mem_ack) m_err = 1;
         if (m_owner == 1) begin
            ia = 1; m_ir = word;
         end else begin
            da = 1;
            if (!m_we) m_dr = word;
         end
         m_owner = 0; m_req = 0;
      end else begin
         m_waited++;
      end
      if (!i_req || gi) m_streak = 0;
      else if (gd && m_streak < MAXS) m_streak++;
      m_ia = ia; m_da = da;
   endtask

   task automatic new_i();
      i_req = 1; i_addr = 32'($urandom_range(1023, 0)) << 2;
   endtask

   task automatic new_d();
      d_req = 1; d_we = 1'($urandom_range(1, 0)); d_be = 4'($urandom_range(15, 1));
      d_addr = 32'($urandom_range(1023, 0)) << 2; d_wdata = $urandom();
   endtask

   // One clock: model update at the edge, compare and drive at the falling edge.
   task automatic step();
      @(posedge clk);
      if (!reset) model_reset();
      else        model_clock();
      @(negedge clk);
      check("mem_req", mem_req, m_req);
      check("mem_we", mem_we, m_we);
      check("mem_be", mem_be, m_be);
      check("mem_addr", mem_addr, m_addr);
      check("mem_wdata", mem_wdata, m_wdata);
      check("i_ack", i_ack, m_ia);
      check("d_ack", d_ack, m_da);
      check("i_rdata", i_rdata, m_ir);
      check("d_rdata", d_rdata, m_dr);
      check("err_timeout", err_timeout, m_err);
      if (auto_mode) begin
         if (i_req) begin
            if (i_ack_prev) begin
               if ($urandom_range(1, 0) == 1) new_i(); else i_req = 0;
            end
         end else if ($urandom_range(3, 0) == 0) new_i();
         if (d_req) begin
            if (d_ack_prev) begin
               if ($urandom_range(1, 0) == 1) new_d(); else d_req = 0;
            end
         end else if ($urandom_range(2, 0) == 0) new_d();
      end
      i_ack_prev = i_ack;
      d_ack_prev = d_ack;
      if (mem_req) begin
         if (mem_cnt == 0) mem_lat = auto_mode ? pick_lat() : next_lat;
         mem_cnt++;
         mem_ack = (mem_lat != 0) && (mem_cnt == mem_lat);
      end else begin
         mem_cnt = 0;
         mem_ack = 0;
      end
      mem_rdata = mem_ack ? mem_word(mem_addr) : $urandom();
      #1;
      check("stall_if", stall_if, i_req & ~m_ia);
      check("stall_mem", stall_mem, d_req & ~m_da);
   endtask

   initial begin
      reset = 0; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
      mem_ack = 0; mem_rdata = 0; auto_mode = 0; next_lat = 1; mem_lat = 0; mem_cnt = 0;
      i_ack_prev = 0; d_ack_prev = 0;
      model_reset();
      repeat (3) step();
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_be", mem_be, 0);
      check("rst_d_rdata", d_rdata, 0);
      check("rst_err", err_timeout, 0);
      reset = 1;
      repeat (2) step();

      // single load, zero-wait memory
      next_lat = 1;
      d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h40; d_wdata = 0;
      #1 check("load_stall_n", stall_mem, 1);
      step();
      check("load_req_n1", mem_req, 1);
      check("load_addr", mem_addr, 32'h40);
      check("load_stall_n1", stall_mem, 1);
      step();
      check("load_req_n2", mem_req, 0);
      check("load_ack_n2", d_ack, 1);
      check("load_rdata", d_rdata, 32'h1234);
      check("load_stall_n2", stall_mem, 0);
      step();
      d_req = 0;

      // store with partial byte enables
      next_lat = 2;
      d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h80; d_wdata = 32'hCAFEF00D;
      step();
      check("st_we", mem_we, 1);
      check("st_be", mem_be, 4'b0011);
      check("st_wdata", mem_wdata, 32'hCAFEF00D);
      step();
      check("st_ack_early", d_ack, 0);
      step();
      check("st_ack", d_ack, 1);
      check("st_rdata_kept", d_rdata, 32'h1234);
      step();
      d_req = 0; d_we = 0;

      // simultaneous requests, 3-cycle memory
      next_lat = 3;
      i_req = 1; i_addr = 32'h100;
      d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h200;
      step();
      check("sim_d_first", mem_addr, 32'h200);
      repeat (3) step();
      check("sim_d_ack", d_ack, 1);
      check("sim_gap", mem_req, 0);
      step();
      d_req = 0;
      check("sim_i_req", mem_req, 1);
      check("sim_i_addr", mem_addr, 32'h100);
      check("sim_i_be", mem_be, 4'hF);
      repeat (3) step();
      check("sim_i_ack", i_ack, 1);
      check("sim_i_rdata", i_rdata, 32'hA5A5_0E0F);
      step();
      i_req = 0;

      // memory never acks: watchdog abort
      next_lat = 0;
      d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h300;
      repeat (8) step();
      check("to_still_busy", mem_req, 1);
      check("to_no_err_yet", err_timeout, 0);
      step();
      check("to_req_drop", mem_req, 0);
      check("to_d_ack", d_ack, 1);
      check("to_rdata", d_rdata, 32'hDEADBEEF);
      check("to_err", err_timeout, 1);
      step();
      d_req = 0;
      next_lat = 1;
      i_req = 1; i_addr = 32'h44;
      repeat (2) step();
      check("to_next_ack", i_ack, 1);
      check("to_next_rdata", i_rdata, 32'hA5A5_0F4B);
      check("to_err_sticky", err_timeout, 1);
      step();
      i_req = 0;

      // reset during a fetch
      next_lat = 5;
      i_req = 1; i_addr = 32'h500;
      repeat (2) step();
      check("rb_busy", mem_req, 1);
      reset = 0; i_req = 0;
      #1;
      check("rb_req_async", mem_req, 0);
      check("rb_ack_async", i_ack, 0);
      check("rb_err_async", err_timeout, 0);
      model_reset();
      repeat (2) step();
      reset = 1;
      step();
      // fresh fetch; ack lands on the watchdog's final cycle
      next_lat = TO;
      i_req = 1; i_addr = 32'h504;
      repeat (9) step();
      check("ra_i_ack", i_ack, 1);
      check("ra_i_rdata", i_rdata, 32'hA5A5_0A0B);
      check("ra_err", err_timeout, 0);
      step();
      i_req = 0;

      // randomized traffic against the model
      auto_mode = 1;
      repeat (4000) step();
      auto_mode = 0;
      i_req = 0; d_req = 0;
      repeat (20) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
